prime_sieve_stream: RTL and testbench

Parametrised Sieve-of-Eratosthenes engine with an internal 1-bit flag memory and a valid/ready prime output stream. On `start` it clears the flag array, sieves all composites up to `LIMIT`, then emits every prime in `[max(base,2), LIMIT]` in ascending order. It sits between the control/key logic and the BCD/7-segment display path. The display side paces the stream, for example by driving `out_ready` from the 1-second tick.

---
 rtl/prime_sieve_stream_if.sv | 24 ++
 rtl/prime_sieve_stream.sv | 135 +++++++++++++
 tb/tb_prime_sieve_stream.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/prime_sieve_stream_if.sv
// Control and prime-stream bundle between the key logic, the sieve engine
// and the display path. master = sieve engine, slave = its client.
interface prime_sieve_stream_if #(
  parameter int AW = 20
) ();
  logic          start;
  logic [AW-1:0] base;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_prime;
  logic [AW-1:0] prime_count;

  modport master (
    input  start, base, out_ready,
    output busy, done, out_valid, out_prime, prime_count
  );

  modport slave (
    output start, base, out_ready,
    input  busy, done, out_valid, out_prime, prime_count
  );
endinterface

// File: rtl/prime_sieve_stream.sv
// Sieve of Eratosthenes over a 1-bit composite-flag memory, streaming every
// prime in [max(base,2), LIMIT] in ascending order over valid/ready.
module prime_sieve_stream #(
  parameter int LIMIT = 999999,
  parameter int AW    = 20
) (
  input  logic                clk,
  input  logic                rstn,
  prime_sieve_stream_if.master bus
);
  localparam int MW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [AW:0]     LIM_X = (AW+1)'(LIMIT);
  localparam logic [2*AW-1:0] LIM_W = (2*AW)'(LIMIT);

  typedef enum logic [3:0] {
    IDLE, CLEAR, SCAN_RD, SCAN_CHK, MARK, EMIT_RD, EMIT_CHK, EMIT_OUT, DONE
  } state_t;

  state_t          state, state_nx;
  logic [AW:0]     a, p, j, j_nx;
  logic [AW-1:0]   i, base_q;
  logic [2*AW-1:0] sq;
  logic [AW-1:0]   out_prime, prime_count;
  logic            wr_en, wr_data, rd_en, flag_q;
  logic [MW-1:0]   wr_addr, rd_addr;
  logic            flag_mem [0:LIMIT];
  logic            idle_like;

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Square at double width so large i never wraps below LIMIT.
  assign sq        = {{AW{1'b0}}, i} * {{AW{1'b0}}, i};
  assign j_nx      = j + {1'b0, i};
  assign idle_like = (state == IDLE) || (state == DONE);

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    wr_data  = 1'b0;
    wr_addr  = a[MW-1:0];
    rd_en    = 1'b0;
    rd_addr  = i[MW-1:0];
    case (state)
      IDLE, DONE: if (bus.start) state_nx = CLEAR;
      CLEAR: begin
        wr_en = 1'b1;
        if (a == LIM_X) state_nx = SCAN_RD;
      end
      SCAN_RD: begin
        if (sq > LIM_W) begin
          state_nx = EMIT_RD;
        end else begin
          rd_en    = 1'b1;
          state_nx = SCAN_CHK;
        end
      end
      SCAN_CHK: state_nx = flag_q ? SCAN_RD : MARK;
      MARK: begin
        wr_en   = 1'b1;
        wr_data = 1'b1;
        wr_addr = j[MW-1:0];
        if (j_nx > LIM_X) state_nx = SCAN_RD;
      end
      EMIT_RD: begin
        if (p > LIM_X) begin
          state_nx = DONE;
        end else begin
          rd_en    = 1'b1;
          rd_addr  = p[MW-1:0];
          state_nx = EMIT_CHK;
        end
      end
      EMIT_CHK: state_nx = flag_q ? EMIT_RD : EMIT_OUT;
      EMIT_OUT: if (bus.out_ready) state_nx = EMIT_RD;
      default:  state_nx = IDLE;
    endcase
  end

  // Flag memory: one write port, registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) flag_mem[wr_addr] <= wr_data;
    if (rd_en) flag_q <= flag_mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      out_prime   <= '0;
      prime_count <= '0;
    end else begin
      state <= state_nx;
      if (idle_like && bus.start) prime_count <= '0;
      if (state == EMIT_CHK && !flag_q) out_prime <= p[AW-1:0];
      if (state == EMIT_OUT && bus.out_ready) prime_count <= sat_inc(prime_count);
    end
  end

  // Walk registers carry no reset; every run reloads them before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          base_q <= bus.base;
          a      <= '0;
        end
      end
      CLEAR: begin
        a <= a + 1'b1;
        if (a == LIM_X) i <= AW'(2);
      end
      SCAN_RD: begin
        if (sq > LIM_W) p <= (base_q < AW'(2)) ? (AW+1)'(2) : {1'b0, base_q};
      end
      SCAN_CHK: begin
        if (flag_q) i <= i + 1'b1;
        else        j <= sq[AW:0];
      end
      MARK: begin
        j <= j_nx;
        if (j_nx > LIM_X) i <= i + 1'b1;
      end
      EMIT_CHK: if (flag_q) p <= p + 1'b1;
      EMIT_OUT: if (bus.out_ready) p <= p + 1'b1;
      default: ;
    endcase
  end

  assign bus.busy        = !idle_like;
  assign bus.done        = (state == DONE);
  assign bus.out_valid   = (state == EMIT_OUT);
  assign bus.out_prime   = out_prime;
  assign bus.prime_count = prime_count;
endmodule

// File: tb/tb_prime_sieve_stream.sv
// Directed bench for prime_sieve_stream: three instances (LIMIT 30, 2, 100)
// checked against a trial-division prime model and a cycle-count model.
module tb_prime_sieve_stream;
  localparam int AW = 20;

  logic clk;
  logic rstn;
  bit   start;
  bit   ready;
  logic [AW-1:0] base_r;
  int   sel;

  prime_sieve_stream_if #(.AW(AW)) i30 ();
  prime_sieve_stream_if #(.AW(AW)) i2 ();
  prime_sieve_stream_if #(.AW(AW)) i100 ();

  prime_sieve_stream #(.LIMIT(30),  .AW(AW)) u30  (.clk(clk), .rstn(rstn), .bus(i30.master));
  prime_sieve_stream #(.LIMIT(2),   .AW(AW)) u2   (.clk(clk), .rstn(rstn), .bus(i2.master));
  prime_sieve_stream #(.LIMIT(100), .AW(AW)) u100 (.clk(clk), .rstn(rstn), .bus(i100.master));

  assign i30.start      = start && (sel == 0);
  assign i2.start       = start && (sel == 1);
  assign i100.start     = start && (sel == 2);
  assign i30.base       = base_r;
  assign i2.base        = base_r;
  assign i100.base      = base_r;
  assign i30.out_ready  = ready;
  assign i2.out_ready   = ready;
  assign i100.out_ready = ready;

  bit m_valid, m_busy, m_done;
  int m_prime, m_count;

  always_comb begin
    m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_prime = 0; m_count = 0;
    case (sel)
      0: begin m_valid = i30.out_valid;  m_busy = i30.busy;  m_done = i30.done;
               m_prime = 32'(i30.out_prime);  m_count = 32'(i30.prime_count); end
      1: begin m_valid = i2.out_valid;   m_busy = i2.busy;   m_done = i2.done;
               m_prime = 32'(i2.out_prime);   m_count = 32'(i2.prime_count); end
      2: begin m_valid = i100.out_valid; m_busy = i100.busy; m_done = i100.done;
               m_prime = 32'(i100.out_prime); m_count = 32'(i100.prime_count); end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int exp_q[$];
  int last_prime;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void push_primes(input int limit, input int lo);
    for (int n = (lo < 2 ? 2 : lo); n <= limit; n++) if (is_prime(n)) exp_q.push_back(n);
  endfunction

  function automatic int n_primes(input int limit, input int lo);
    int c = 0;
    for (int n = (lo < 2 ? 2 : lo); n <= limit; n++) if (is_prime(n)) c++;
    return c;
  endfunction

  // Cycles spent from the first SCAN_RD to the first EMIT_RD.
  function automatic int sieve_cycles(input int limit);
    int c = 0;
    for (int k = 2; k * k <= limit; k++)
      c += is_prime(k) ? 2 + (limit - k * k) / k + 1 : 2;
    return c + 1;
  endfunction

  task automatic do_start(input int b);
    @(negedge clk);
    base_r = AW'(b);
    start  = 1'b1;
  endtask

  // n counts negedges after the start edge; n=0 sees the first CLEAR cycle.
  task automatic collect(input int rmode, input int restart_at, input int abort_prime,
                         input int budget, output int first_v, output int done_n,
                         output bit aborted);
    bit held_v;
    int held_p;
    bit rdy;
    first_v = -1; done_n = -1; aborted = 1'b0; held_v = 1'b0; held_p = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (n == 0) chk("busy_rise", int'(m_busy), 1);
      if (held_v) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_prime", m_prime, held_p);
      end
      if (m_done) begin done_n = n; break; end
      if (m_valid && first_v < 0) first_v = n;
      if (abort_prime >= 0 && m_valid && m_prime == abort_prime) begin
        ready = 1'b0; start = 1'b0; aborted = 1'b1; break;
      end
      start = (n == restart_at);
      rdy   = (rmode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      ready = rdy;
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) chk("extra_prime", m_prime, -1);
        else chk("prime", m_prime, exp_q.pop_front());
        last_prime = m_prime;
      end
      held_v = m_valid && !rdy;
      held_p = m_prime;
    end
    start = 1'b0;
    if (!aborted) chk("done_seen", int'(m_done), 1);
  endtask

  task automatic check_end(input int count);
    chk("done", int'(m_done), 1);
    chk("busy_low", int'(m_busy), 0);
    chk("valid_low", int'(m_valid), 0);
    chk("prime_count", m_count, count);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  int  fv, dn;
  bit  ab;

  initial begin
    rstn = 1'b0; start = 1'b0; ready = 1'b0; base_r = '0; sel = 0; last_prime = 0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", int'(m_busy), 0);
      chk("rst_done", int'(m_done), 0);
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_prime", m_prime, 0);
      chk("rst_count", m_count, 0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // LIMIT=30, base=0, always ready
    sel = 0;
    push_primes(30, 0);
    do_start(0);
    collect(0, -1, -1, 2000, fv, dn, ab);
    chk("first_valid_cycle", fv, 31 + sieve_cycles(30) + 2);
    check_end(10);
    chk("last_prime_30", last_prime, 29);

    // LIMIT=30, base=20, ~30% ready
    push_primes(30, 20);
    do_start(20);
    collect(1, -1, -1, 3000, fv, dn, ab);
    check_end(2);

    // LIMIT=2: sieve skipped
    sel = 1;
    push_primes(2, 0);
    do_start(0);
    collect(0, -1, -1, 500, fv, dn, ab);
    chk("first_valid_lim2", fv, 3 + sieve_cycles(2) + 2);
    check_end(1);

    // LIMIT=30, base=31: nothing emitted, CLEAR is 31 cycles
    sel = 0;
    do_start(31);
    collect(0, -1, -1, 500, fv, dn, ab);
    chk("no_valid", fv, -1);
    chk("done_cycle", dn, 31 + sieve_cycles(30) + 1);
    check_end(0);

    // LIMIT=100, stray start while busy, then rerun from DONE
    sel = 2;
    push_primes(100, 0);
    do_start(0);
    collect(0, 10, -1, 3000, fv, dn, ab);
    check_end(n_primes(100, 0));
    chk("last_prime_100", last_prime, 97);
    push_primes(100, 0);
    do_start(0);
    collect(0, -1, -1, 3000, fv, dn, ab);
    check_end(25);
    chk("rerun_last", last_prime, 97);

    // LIMIT=100, asynchronous reset while 41 is presented
    push_primes(100, 0);
    do_start(0);
    collect(0, -1, 41, 3000, fv, dn, ab);
    chk("reached_41", int'(ab), 1);
    chk("stall_prime_41", m_prime, 41);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", int'(m_busy), 0);
    chk("arst_done", int'(m_done), 0);
    chk("arst_valid", int'(m_valid), 0);
    chk("arst_prime", m_prime, 0);
    chk("arst_count", m_count, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    push_primes(100, 0);
    do_start(0);
    collect(0, -1, -1, 3000, fv, dn, ab);
    check_end(25);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
